resampler_frame_ctrl: RTL

Frame sequencer between the FFT output stream and the resampler. Admits one 4096-bin frame at a time, checks bin ordering and framing, and latches a clamped scale factor at each frame start. Holds the FFT stream off until the resampler reports the previous frame done. Exposes frame/error counters for debug.

---
 rtl/resampler_frame_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/resampler_frame_ctrl.sv
// Frame sequencer between the FFT bin stream and the resampler: admits one ordered frame at a
// time, latches a clamped scale factor at bin 0 and holds the stream off until the frame drains.
module resampler_frame_ctrl #(
  parameter int unsigned          FRAME_LEN     = 4096,
  parameter int unsigned          ADDR_W        = 13,
  parameter int unsigned          DATA_W        = 80,
  parameter int unsigned          SCALE_W       = 24,
  parameter logic [SCALE_W-1:0]   SCALE_MIN     = 24'h040000,
  parameter logic [SCALE_W-1:0]   SCALE_MAX     = 24'h400000,
  parameter int unsigned          DRAIN_TIMEOUT = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [ADDR_W-1:0]  s_user,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic [SCALE_W-1:0] sf_in,
  input  logic               sf_valid,
  output logic [DATA_W-1:0]  r_data,
  output logic [ADDR_W-1:0]  r_user,
  output logic               r_valid,
  output logic               r_last,
  output logic               r_abort,
  output logic [SCALE_W-1:0] r_scale,
  output logic               r_scale_valid,
  input  logic               rs_done,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [7:0]         err_cnt,
  output logic               err_sticky,
  input  logic               err_clr
);

  localparam int unsigned        TMR_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(32'h0010_0000);

  typedef enum logic [1:0] {StIdle, StStream, StDiscard, StDrain} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  exp_q, exp_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               bad_run_q, bad_run_d;
  logic               s_ready_q, s_ready_d;
  logic [DATA_W-1:0]  r_data_q, r_data_d;
  logic [ADDR_W-1:0]  r_user_q, r_user_d;
  logic               r_valid_q, r_valid_d;
  logic               r_last_q, r_last_d;
  logic               r_abort_q, r_abort_d;
  logic [SCALE_W-1:0] r_scale_q, r_scale_d;
  logic               r_scale_valid_q, r_scale_valid_d;
  logic [SCALE_W-1:0] sf_pend_q, sf_pend_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               err_sticky_q, err_sticky_d;
  logic               accept, err_ev;

  function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] v);
    if (v < SCALE_MIN)      return SCALE_MIN;
    else if (v > SCALE_MAX) return SCALE_MAX;
    else                    return v;
  endfunction

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d         = state_q;
    exp_d           = exp_q;
    timer_d         = '0;
    // A run of stray beats only counts while we stay in IDLE.
    bad_run_d       = bad_run_q && (state_q == StIdle);
    r_data_d        = r_data_q;
    r_user_d        = r_user_q;
    r_valid_d       = 1'b0;
    r_last_d        = 1'b0;
    r_abort_d       = 1'b0;
    r_scale_d       = r_scale_q;
    r_scale_valid_d = 1'b0;
    sf_pend_d       = sf_valid ? sf_in : sf_pend_q;
    frame_cnt_d     = frame_cnt_q;
    err_ev          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Bin 0 with s_last is only a complete frame when a frame is one bin long.
          if (s_user == '0 && !(s_last && FRAME_LEN != 1)) begin
            r_valid_d       = 1'b1;
            r_data_d        = s_data;
            r_user_d        = s_user;
            r_scale_d       = clamp_scale(sf_pend_q);
            r_scale_valid_d = 1'b1;
            exp_d           = ADDR_W'(1);
            bad_run_d       = 1'b0;
            if (s_last) begin
              r_last_d = 1'b1;
              state_d  = StDrain;
            end else begin
              state_d  = StStream;
            end
          end else begin
            err_ev    = !bad_run_q;
            bad_run_d = !s_last;
          end
        end
      end
      StStream: begin
        if (accept) begin
          if (s_user == exp_q && exp_q < LAST_IDX && !s_last) begin
            r_valid_d = 1'b1;
            r_data_d  = s_data;
            r_user_d  = s_user;
            exp_d     = exp_q + ADDR_W'(1);
          end else if (s_user == LAST_IDX && exp_q == LAST_IDX && s_last) begin
            r_valid_d = 1'b1;
            r_data_d  = s_data;
            r_user_d  = s_user;
            r_last_d  = 1'b1;
            state_d   = StDrain;
          end else begin
            r_abort_d = 1'b1;
            err_ev    = 1'b1;
            state_d   = s_last ? StIdle : StDiscard;
          end
        end
      end
      StDiscard: begin
        if (accept && s_last) state_d = StIdle;
      end
      StDrain: begin
        if (rs_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StIdle;
        end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
          err_ev    = 1'b1;
          r_abort_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    s_ready_d = (state_d != StDrain);

    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (err_ev) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      exp_q           <= '0;
      timer_q         <= '0;
      bad_run_q       <= 1'b0;
      s_ready_q       <= 1'b0;
      r_data_q        <= '0;
      r_user_q        <= '0;
      r_valid_q       <= 1'b0;
      r_last_q        <= 1'b0;
      r_abort_q       <= 1'b0;
      r_scale_q       <= SCALE_ONE;
      r_scale_valid_q <= 1'b0;
      sf_pend_q       <= SCALE_ONE;
      frame_cnt_q     <= '0;
      err_cnt_q       <= '0;
      err_sticky_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_q           <= exp_d;
      timer_q         <= timer_d;
      bad_run_q       <= bad_run_d;
      s_ready_q       <= s_ready_d;
      r_data_q        <= r_data_d;
      r_user_q        <= r_user_d;
      r_valid_q       <= r_valid_d;
      r_last_q        <= r_last_d;
      r_abort_q       <= r_abort_d;
      r_scale_q       <= r_scale_d;
      r_scale_valid_q <= r_scale_valid_d;
      sf_pend_q       <= sf_pend_d;
      frame_cnt_q     <= frame_cnt_d;
      err_cnt_q       <= err_cnt_d;
      err_sticky_q    <= err_sticky_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign r_data        = r_data_q;
  assign r_user        = r_user_q;
  assign r_valid       = r_valid_q;
  assign r_last        = r_last_q;
  assign r_abort       = r_abort_q;
  assign r_scale       = r_scale_q;
  assign r_scale_valid = r_scale_valid_q;
  assign busy          = (state_q != StIdle);
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign err_sticky    = err_sticky_q;

endmodule
